// File: rtl/vga_video_out.sv
// -----------------------------------------------------------------------------
// vga_video_out
//   Video timing generator and pixel-stream sequencer for the TMDS encoders.
//   A free-running h/v raster (pixel clock domain) pulls RGB888 pixels from a
//   valid/ready stream that marks pixel (0,0) with a start-of-frame flag. All
//   video outputs are registered, so the pins lag the raster counters by one
//   cycle. Underflow and framing errors blank the offending slot, raise a
//   sticky error bit and drop the sequencer back to hunting for the next SOF.
//
// Ports
//   i_clk          pixel clock (25 MHz)
//   i_rstn         asynchronous active-low reset
//   i_enable       run timing; low = blank outputs and hold raster at (0,0)
//   i_px_valid     stream pixel valid
//   i_px_sof       stream pixel is (0,0) of a frame
//   i_px_data      stream pixel {r,g,b}
//   o_px_ready     pixel consumed this cycle when i_px_valid & o_px_ready
//   o_data_en      active-video qualifier
//   o_hsync        horizontal sync, active level HS_POL
//   o_vsync        vertical sync, active level VS_POL
//   o_r/o_g/o_b    pixel colour, 0 when blanked
//   o_frame_start  one-cycle pulse alongside output pixel (0,0)
//   o_err          sticky errors: [0] underflow, [1] framing
//   i_err_clr      clears o_err; a new error in the same cycle wins
// -----------------------------------------------------------------------------
module vga_video_out #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_enable,
  input  logic        i_px_valid,
  input  logic        i_px_sof,
  input  logic [23:0] i_px_data,
  output logic        o_px_ready,
  output logic        o_data_en,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic [7:0]  o_r,
  output logic [7:0]  o_g,
  output logic [7:0]  o_b,
  output logic        o_frame_start,
  output logic [1:0]  o_err,
  input  logic        i_err_clr
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEEK   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [HW-1:0] h;
  logic [VW-1:0] v;

  logic       run;
  logic       active;
  logic       at_origin;
  logic       hs_on;
  logic       vs_on;
  logic       take;
  logic [1:0] err_set;

  // Raster runs only while enabled and out of IDLE; IDLE parks it at (0,0).
  assign run       = i_enable && (state != ST_IDLE);
  assign active    = (h < H_ACT) && (v < V_ACT);
  assign at_origin = (h == '0) && (v == '0);
  assign hs_on     = (h >= HS_FIRST) && (h <= HS_LAST);
  assign vs_on     = (v >= VS_FIRST) && (v <= VS_LAST);

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    o_px_ready = 1'b0;
    take       = 1'b0;
    err_set    = 2'b00;
    case (state)
      ST_IDLE: begin
        if (i_enable) state_nxt = ST_SEEK;
      end
      ST_SEEK: begin
        // Non-SOF pixels are drained in active slots; a SOF pixel waits for
        // (0,0). Blanking slots never take anything from the stream.
        o_px_ready = active && (!i_px_sof || at_origin);
        if (i_px_valid && o_px_ready && i_px_sof) begin
          take      = 1'b1;
          state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        o_px_ready = active && !(i_px_sof ^ at_origin);
        if (active) begin
          if (!i_px_valid) begin
            err_set[0] = 1'b1;
            state_nxt  = ST_SEEK;
          end else if (i_px_sof ^ at_origin) begin
            // SOF in the wrong place (or missing at the origin): leave the
            // pixel in the stream so SEEK can pick it up at the next (0,0).
            err_set[1] = 1'b1;
            state_nxt  = ST_SEEK;
          end else begin
            take = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Dropping enable aborts at once, whatever the state.
    if (!i_enable) begin
      state_nxt  = ST_IDLE;
      o_px_ready = 1'b0;
      take       = 1'b0;
      err_set    = 2'b00;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= ST_IDLE;
      h     <= '0;
      v     <= '0;
    end else begin
      state <= state_nxt;
      if (!run) begin
        h <= '0;
        v <= '0;
      end else if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // Output stage: one cycle behind the raster counters.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_data_en     <= 1'b0;
      o_hsync       <= ~HS_POL;
      o_vsync       <= ~VS_POL;
      o_r           <= '0;
      o_g           <= '0;
      o_b           <= '0;
      o_frame_start <= 1'b0;
    end else if (!run) begin
      o_data_en     <= 1'b0;
      o_hsync       <= ~HS_POL;
      o_vsync       <= ~VS_POL;
      o_r           <= '0;
      o_g           <= '0;
      o_b           <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_data_en     <= active;
      o_hsync       <= hs_on ? HS_POL : ~HS_POL;
      o_vsync       <= vs_on ? VS_POL : ~VS_POL;
      o_r           <= take ? i_px_data[23:16] : 8'h00;
      o_g           <= take ? i_px_data[15:8]  : 8'h00;
      o_b           <= take ? i_px_data[7:0]   : 8'h00;
      o_frame_start <= at_origin;
    end
  end

  // Sticky error flags; a set in the same cycle as a clear takes priority.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_err <= 2'b00;
    end else begin
      o_err <= (o_err & ~{2{i_err_clr}}) | err_set;
    end
  end

endmodule
